// File: rtl/ngc_counter_arbiter.sv
// ngc_counter_arbiter: round-robin arbiter granting a shared interval counter to NUM_REQ requesters.
// Define NGC_COUNTER_ARBITER_ABORT_EN to add a per-requester abort input.
module ngc_counter_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int COUNT_WIDTH = 8,
    localparam int IW         = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1,
    localparam int SW         = COUNT_WIDTH / 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQ-1:0]             req,
    input  logic [NUM_REQ*COUNT_WIDTH-1:0] req_ticks,
    output logic [NUM_REQ-1:0]             done,
    output logic                           busy,
    output logic [IW-1:0]                  grant_id,
    output logic                           cnt_rst,
    output logic                           cnt_load,
    output logic                           cnt_enb,
    output logic                           cnt_dir,
    output logic                           cnt_one_shot,
    output logic [COUNT_WIDTH-1:0]         cnt_load_value,
    output logic [COUNT_WIDTH-1:0]         cnt_count_from_value,
    output logic [COUNT_WIDTH-1:0]         cnt_count_to_value,
    output logic [SW-1:0]                  cnt_step_value,
    input  logic [COUNT_WIDTH-1:0]         cnt_count,
    input  logic                           cnt_count_hit
`ifdef NGC_COUNTER_ARBITER_ABORT_EN
    ,
    input  logic [NUM_REQ-1:0]             abort
`endif
);
    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;
    state_t state;
    logic [IW-1:0] rr_ptr, pick, next_ptr;
    logic [COUNT_WIDTH-1:0] pick_ticks;
    logic aborting, unused;
    assign cnt_rst = rst;
    assign unused = ^cnt_count;
    assign next_ptr = (grant_id == IW'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
    assign pick_ticks = req_ticks[int'(pick)*COUNT_WIDTH +: COUNT_WIDTH];
`ifdef NGC_COUNTER_ARBITER_ABORT_EN
    assign aborting = abort[grant_id] && (state == LOAD || state == RUN);
`else
    assign aborting = 1'b0;
`endif
    // Descending scan so the lowest offset from rr_ptr is the last (winning) assignment.
    always_comb begin
        pick = rr_ptr;
        for (int i = NUM_REQ - 1; i >= 0; i--)
            if (req[(int'(rr_ptr) + i) % NUM_REQ]) pick = IW'((int'(rr_ptr) + i) % NUM_REQ);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state                <= IDLE;
            rr_ptr               <= '0;
            busy                 <= 1'b0;
            grant_id             <= '0;
            done                 <= '0;
            cnt_load             <= 1'b0;
            cnt_enb              <= 1'b0;
            cnt_dir              <= 1'b0;
            cnt_one_shot         <= 1'b0;
            cnt_load_value       <= '0;
            cnt_count_from_value <= '0;
            cnt_count_to_value   <= '0;
            cnt_step_value       <= '0;
        end else if (aborting) begin
            state    <= IDLE;
            cnt_load <= 1'b0;
            cnt_enb  <= 1'b0;
            busy     <= 1'b0;
            rr_ptr   <= next_ptr;
        end else begin
            done <= '0;
            case (state)
                IDLE: if (|req) begin
                    grant_id <= pick;
                    busy     <= 1'b1;
                    if (pick_ticks == '0) begin
                        state      <= DONE;
                        done[pick] <= 1'b1;
                    end else begin
                        state                <= LOAD;
                        cnt_load             <= 1'b1;
                        cnt_dir              <= 1'b1;
                        cnt_one_shot         <= 1'b1;
                        cnt_step_value       <= SW'(1);
                        cnt_load_value       <= '0;
                        cnt_count_from_value <= '0;
                        cnt_count_to_value   <= pick_ticks;
                    end
                end
                LOAD: begin
                    state    <= RUN;
                    cnt_load <= 1'b0;
                    cnt_enb  <= 1'b1;
                end
                RUN: if (cnt_count_hit) begin
                    state          <= DONE;
                    cnt_enb        <= 1'b0;
                    done[grant_id] <= 1'b1;
                end
                DONE: begin
                    state  <= IDLE;
                    busy   <= 1'b0;
                    rr_ptr <= next_ptr;
                end
            endcase
        end
    end
endmodule
